axis_upsizer: RTL and testbench

Single-clock AXI-Stream width upsizer: packs `RATIO = WIDTH_S/WIDTH_P` consecutive narrow input beats into one wide output beat. It is the inverse of the 64→32 `axi_cdc` downsizing path: it rebuilds 64-bit words from the 32-bit stream on the secondary side. Packets are preserved. A packet that ends mid-word is flushed as a partial beat with a lane-valid mask.

---
 rtl/axis_upsizer_pkg.sv | 20 ++
 rtl/axis_out_reg.sv | 52 +++++
 rtl/axis_upsizer.sv | 126 ++++++++++++
 tb/tb_axis_upsizer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_upsizer_pkg.sv
// Shared types and helpers for the AXI-Stream width upsizer.
// Holds the width ratio, lane counter width, FSM states and lane-order helper.
package axis_upsizer_pkg;

    typedef enum logic {IDLE, FILL} state_t;

    function automatic int calc_ratio(input int width_p, input int width_s);
        return width_s / width_p;
    endfunction

    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Physical lane written by the cnt-th beat of a word for the given order bit
    function automatic int lane_idx(input int cnt, input logic ord, input int ratio);
        return ord ? (ratio - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream holding register with keep/last; reusable by width adapters.
// Upstream may load whenever the slot is empty or being drained this cycle.
module axis_out_reg #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] data_p0;
    logic [KEEP_W-1:0] keep_p0;
    logic              last_p0;
    logic              vld_p0;

    assign in_ready  = !vld_p0 | out_ready;
    assign out_data  = data_p0;
    assign out_keep  = keep_p0;
    assign out_last  = last_p0;
    assign out_valid = vld_p0;

    // Output stage: a new word wins over a simultaneous drain
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_p0 <= '0;
            keep_p0 <= '0;
            last_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else if (load) begin
            data_p0 <= load_data;
            keep_p0 <= load_keep;
            last_p0 <= load_last;
            vld_p0  <= 1'b1;
        end else if (vld_p0 && out_ready) begin
            data_p0 <= '0;
            keep_p0 <= '0;
            last_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_upsizer.sv
// AXI-Stream upsizer: packs WIDTH_S/WIDTH_P narrow beats into one wide word, flushing partial words on last.
// Optional completed-packet counter pkt_cnt is built when AXIS_UPSIZER_STATS_EN is defined.
module axis_upsizer
    import axis_upsizer_pkg::*;
#(
    parameter  int WIDTH_P = 32,
    parameter  int WIDTH_S = 64,
    localparam int RATIO   = calc_ratio(WIDTH_P, WIDTH_S)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               cfg,
    input  logic [WIDTH_P-1:0] p_axis_data,
    input  logic               p_axis_valid,
    input  logic               p_axis_last,
    output logic               p_axis_ready,
    output logic [WIDTH_S-1:0] s_axis_data,
    output logic [RATIO-1:0]   s_axis_keep,
    output logic               s_axis_valid,
    output logic               s_axis_last,
    input  logic               s_axis_ready
`ifdef AXIS_UPSIZER_STATS_EN
    ,
    output logic [15:0]        pkt_cnt
`endif
);

    localparam int LANE_W = lane_w(RATIO);

    state_t             state_q, state_d;
    logic [LANE_W-1:0]  lane_cnt_q, lane_cnt_d;
    logic               ord_q, ord_d;
    logic [WIDTH_S-1:0] acc_data_q, acc_data_d;
    logic [RATIO-1:0]   acc_keep_q, acc_keep_d;
    logic [WIDTH_S-1:0] word_data;
    logic [RATIO-1:0]   word_keep;
    logic               in_ready;
    logic               accept;
    logic               close;
    logic               ord_cur;
    int                 idx;

    assign p_axis_ready = in_ready;
    assign accept       = p_axis_valid & in_ready;
    // Order bit is taken live on the first beat, then held for the rest of the word
    assign ord_cur      = (state_q == IDLE) ? cfg : ord_q;
    assign close        = accept & (p_axis_last | (lane_cnt_q == LANE_W'(RATIO - 1)));

    always_comb begin
        word_data = acc_data_q;
        word_keep = acc_keep_q;
        idx       = lane_idx(int'(lane_cnt_q), ord_cur, RATIO);
        for (int i = 0; i < RATIO; i++) begin
            if (i == idx) begin
                word_data[i*WIDTH_P +: WIDTH_P] = p_axis_data;
                word_keep[i]                    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        ord_d      = ord_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        if (close) begin
            state_d    = IDLE;
            lane_cnt_d = '0;
            acc_data_d = '0;
            acc_keep_d = '0;
        end else if (accept) begin
            state_d    = FILL;
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
            ord_d      = ord_cur;
            acc_data_d = word_data;
            acc_keep_d = word_keep;
        end
    end

    // Accumulator stage
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            ord_q      <= 1'b0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            ord_q      <= ord_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
        end
    end

    axis_out_reg #(
        .DATA_W (WIDTH_S),
        .KEEP_W (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .nrst      (nrst),
        .load      (close),
        .load_data (word_data),
        .load_keep (word_keep),
        .load_last (p_axis_last),
        .in_ready  (in_ready),
        .out_data  (s_axis_data),
        .out_keep  (s_axis_keep),
        .out_last  (s_axis_last),
        .out_valid (s_axis_valid),
        .out_ready (s_axis_ready)
    );

`ifdef AXIS_UPSIZER_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pkt_cnt <= '0;
        end else if (s_axis_valid && s_axis_ready && s_axis_last && (pkt_cnt != 16'hFFFF)) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_upsizer.sv
// Scoreboard bench for axis_upsizer: directed packing/order/backpressure/reset cases plus random packets.
// Optionally checks pkt_cnt when AXIS_UPSIZER_STATS_EN is defined.
module tb_axis_upsizer;

    localparam int WP = 32;
    localparam int WS = 64;
    localparam int R  = WS / WP;

    typedef struct {
        logic [WS-1:0] d;
        logic [R-1:0]  k;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          cfg = 1'b0;
    logic [WP-1:0] p_axis_data = '0;
    logic          p_axis_valid = 1'b0;
    logic          p_axis_last = 1'b0;
    logic          p_axis_ready;
    logic [WS-1:0] s_axis_data;
    logic [R-1:0]  s_axis_keep;
    logic          s_axis_valid;
    logic          s_axis_last;
    logic          s_axis_ready;
`ifdef AXIS_UPSIZER_STATS_EN
    logic [15:0]   pkt_cnt;
`endif

    int            n_tests = 0;
    int            n_fail = 0;
    exp_t          exp_q[$];
    int            m_cnt = 0;
    logic          m_ord = 1'b0;
    logic [WS-1:0] m_data = '0;
    logic [R-1:0]  m_keep = '0;
    int            m_pkts = 0;
    logic          rand_rdy = 1'b0;
    logic          rdy_force = 1'b1;

    axis_upsizer #(.WIDTH_P(WP), .WIDTH_S(WS)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .cfg          (cfg),
        .p_axis_data  (p_axis_data),
        .p_axis_valid (p_axis_valid),
        .p_axis_last  (p_axis_last),
        .p_axis_ready (p_axis_ready),
        .s_axis_data  (s_axis_data),
        .s_axis_keep  (s_axis_keep),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready)
`ifdef AXIS_UPSIZER_STATS_EN
        ,
        .pkt_cnt      (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference packing of one accepted beat
    task automatic model_accept(input logic [WP-1:0] data, input logic last, input logic c);
        int   li;
        exp_t e;
        if (m_cnt == 0) m_ord = c;
        li = m_ord ? (R - 1 - m_cnt) : m_cnt;
        m_data[li*WP +: WP] = data;
        m_keep[li] = 1'b1;
        m_cnt++;
        if (last || m_cnt == R) begin
            e.d = m_data;
            e.k = m_keep;
            e.l = last;
            exp_q.push_back(e);
            m_cnt  = 0;
            m_data = '0;
            m_keep = '0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the handshake edge
    task automatic send(input logic [WP-1:0] data, input logic last, input logic c);
        int n;
        n = 0;
        p_axis_data  = data;
        p_axis_last  = last;
        p_axis_valid = 1'b1;
        cfg          = c;
        forever begin
            @(negedge clk);
            if (p_axis_ready) break;
            n++;
            if (n > 1000) begin
                check("p_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        if (n <= 1000) model_accept(data, last, c);
        @(posedge clk);
        #1;
        p_axis_valid = 1'b0;
        p_axis_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [WS-1:0] d, input logic [R-1:0] k, input logic l);
        @(negedge clk);
        check({tag, "_valid"}, s_axis_valid, 1'b1);
        check({tag, "_data"}, s_axis_data, d);
        check({tag, "_keep"}, s_axis_keep, k);
        check({tag, "_last"}, s_axis_last, l);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || s_axis_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        s_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            s_axis_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: hold stability, ready rule and scoreboard compare
    initial begin
        logic          hold;
        logic [WS-1:0] h_data;
        logic [R-1:0]  h_keep;
        logic          h_last;
        exp_t          e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                hold = 1'b0;
            end else begin
                check("p_ready_rule", p_axis_ready, !s_axis_valid | s_axis_ready);
                if (hold) begin
                    check("hold_valid", s_axis_valid, 1'b1);
                    check("hold_data", s_axis_data, h_data);
                    check("hold_keep", s_axis_keep, h_keep);
                    check("hold_last", s_axis_last, h_last);
                end
                hold   = s_axis_valid & !s_axis_ready;
                h_data = s_axis_data;
                h_keep = s_axis_keep;
                h_last = s_axis_last;
                if (s_axis_valid && s_axis_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", s_axis_data, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", s_axis_data, e.d);
                        check("sb_keep", s_axis_keep, e.k);
                        check("sb_last", s_axis_last, e.l);
                        if (e.l) m_pkts++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int gap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_p_ready", p_axis_ready, 1'b1);
        check("rst_s_valid", s_axis_valid, 1'b0);
        check("rst_s_last", s_axis_last, 1'b0);
        check("rst_s_keep", s_axis_keep, '0);
        check("rst_s_data", s_axis_data, '0);
`ifdef AXIS_UPSIZER_STATS_EN
        check("rst_pkt_cnt", pkt_cnt, 16'd0);
`endif
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        send(32'h11111111, 1'b0, 1'b0);
        send(32'h22222222, 1'b1, 1'b0);
        expect_out("cfg0", 64'h22222222_11111111, 2'b11, 1'b1);

        send(32'h11111111, 1'b0, 1'b1);
        send(32'h22222222, 1'b1, 1'b1);
        expect_out("cfg1", 64'h11111111_22222222, 2'b11, 1'b1);

        send(32'hAAAA0001, 1'b0, 1'b0);
        send(32'hBBBB0002, 1'b0, 1'b0);
        expect_out("three_w1", 64'hBBBB0002_AAAA0001, 2'b11, 1'b0);
        send(32'hCCCC0003, 1'b1, 1'b0);
        expect_out("three_w2", 64'h00000000_CCCC0003, 2'b01, 1'b1);

        send(32'h5A5A5A5A, 1'b1, 1'b1);
        expect_out("single_cfg1", 64'h5A5A5A5A_00000000, 2'b10, 1'b1);

        send(32'h0000000A, 1'b0, 1'b0);
        send(32'h0000000B, 1'b1, 1'b1);
        expect_out("cfg_toggle", 64'h0000000B_0000000A, 2'b11, 1'b1);

        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(32'h0000A001, 1'b0, 1'b0);
        send(32'h0000B002, 1'b1, 1'b0);
        p_axis_data  = 32'h0000C003;
        p_axis_last  = 1'b1;
        p_axis_valid = 1'b1;
        cfg          = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_p_ready", p_axis_ready, 1'b0);
            check("bp_s_valid", s_axis_valid, 1'b1);
            check("bp_data", s_axis_data, 64'h0000B002_0000A001);
        end
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        send(32'h0000C003, 1'b1, 1'b0);
        drain();

        send(32'hDEAD0001, 1'b0, 1'b0);
        nrst = 1'b0;
        m_cnt  = 0;
        m_data = '0;
        m_keep = '0;
        exp_q.delete();
        m_pkts = 0;
        @(negedge clk);
        check("mid_rst_p_ready", p_axis_ready, 1'b1);
        check("mid_rst_s_valid", s_axis_valid, 1'b0);
        check("mid_rst_s_keep", s_axis_keep, '0);
        check("mid_rst_s_data", s_axis_data, '0);
        check("mid_rst_s_last", s_axis_last, 1'b0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        send(32'h12345678, 1'b0, 1'b0);
        send(32'h9ABCDEF0, 1'b1, 1'b0);
        expect_out("post_rst", 64'h9ABCDEF0_12345678, 2'b11, 1'b1);

        rand_rdy = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                send($urandom, (b == len - 1), 1'($urandom_range(0, 1)));
            end
        end
        rand_rdy = 1'b0;
        drain();

`ifdef AXIS_UPSIZER_STATS_EN
        @(negedge clk);
        check("pkt_cnt", pkt_cnt, m_pkts[15:0]);
`endif
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
